// File: rtl/i2c_master_wr.sv
// Single-master I2C write engine: START, address+W, ACK, one data byte, ACK, STOP.
// SCL bit period is 4*CLK_DIV clk cycles, split into four quarter phases.
// Optional feature macro: I2C_CLK_STRETCH_EN adds scl_in and holds the bit timer
// while a slave keeps SCL low after the master releases it.
module i2c_master_wr #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  inout  wire        sda,
  output logic       scl,
  output logic       busy,
  output logic       done,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       scl_in,
`endif
  output logic       ack_err
);

  localparam int unsigned QcW = $clog2(CLK_DIV);
  localparam logic [QcW-1:0] QcLast = QcW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAddrAck, StData, StDataAck, StStop
  } state_e;

  state_e         state_q, state_d;
  logic [QcW-1:0] qc_q, qc_d;
  logic [1:0]     ph_q, ph_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           ack_err_q, ack_err_d;

  logic sda_in;
  logic sda_low;
  logic qc_wrap;
  logic bit_end;
  logic sample;
  logic stall;

  assign sda_in  = sda;
  assign qc_wrap = (qc_q == QcLast);
  assign bit_end = qc_wrap && (ph_q == 2'd3);
  assign sample  = (ph_q == 2'd3) && (qc_q == '0);

`ifdef I2C_CLK_STRETCH_EN
  // Hold at the instant SCL is released high until the line actually reads high.
  assign stall = (state_q != StIdle) && (ph_q == 2'd2) && (qc_q == '0) && !scl_in;
`else
  assign stall = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      qc_q      <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qc_q      <= qc_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Next-state: accept, bit timer, ACK sampling and bit-boundary transitions.
  always_comb begin
    state_d   = state_q;
    qc_d      = qc_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;

    if (state_q == StIdle) begin
      if (start) begin
        state_d   = StStart;
        qc_d      = '0;
        ph_d      = '0;
        bit_d     = 3'd7;
        shift_d   = {addr, 1'b0};
        data_d    = data_in;
        ack_err_d = 1'b0;
      end
    end else if (!stall) begin
      qc_d = qc_wrap ? '0 : qc_q + QcW'(1);
      if (qc_wrap) begin
        ph_d = ph_q + 2'd1;
      end
      // Slave drives the ACK bit low; a released (high) line is a NACK.
      if (sample && (state_q == StAddrAck || state_q == StDataAck) && sda_in) begin
        ack_err_d = 1'b1;
      end
      if (bit_end) begin
        unique case (state_q)
          StStart: begin
            state_d = StAddr;
            bit_d   = 3'd7;
          end
          StAddr: begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_q == 3'd0) begin
              state_d = StAddrAck;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
          StAddrAck: begin
            // ack_err_q was updated at this bit's sample point, earlier in the bit.
            if (ack_err_q) begin
              state_d = StStop;
            end else begin
              state_d = StData;
              shift_d = data_q;
              bit_d   = 3'd7;
            end
          end
          StData: begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_q == 3'd0) begin
              state_d = StDataAck;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
          StDataAck: state_d = StStop;
          StStop:    state_d = StIdle;
          default:   state_d = StIdle;
        endcase
      end
    end
  end

  // Line drivers decoded from state and phase; reset forces both lines released.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      StIdle: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
      StStart: begin
        scl     = 1'b1;
        sda_low = ph_q[1];
      end
      StAddr, StData: begin
        scl     = ph_q[1];
        sda_low = ~shift_q[7];
      end
      StAddrAck, StDataAck: begin
        scl     = ph_q[1];
        sda_low = 1'b0;
      end
      StStop: begin
        scl     = ph_q[1];
        sda_low = (ph_q != 2'd3);
      end
      default: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
    endcase
  end

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StStop) && bit_end;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: a time-indexed bus model derives the expected SCL/SDA,
// busy, done and ack_err for every cycle; a bus decoder recovers the bytes sent.
module tb_i2c_master_wr;

  localparam int D = 4;
  localparam int B = 4 * D;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data_in;
  wire        sda;
  logic       scl;
  logic       busy;
  logic       done;
  logic       ack_err;
  bit         hold = 1'b0;

  bit sl_ack_a = 1'b1;
  bit sl_ack_d = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Bus model state: transaction parameters and cycle index since accept.
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [6:0] m_addr = '0;
  logic [7:0] m_data = '0;
  bit         m_ack_a = 1'b1;
  bit         m_ack_d = 1'b1;
  bit         m_ack_err = 1'b0;

  wire slave_pull = m_active &&
                    ((m_t / B == 9 && m_ack_a) || (m_t / B == 18 && m_ack_a && m_ack_d));

  pullup (sda);
  assign sda = slave_pull ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  wire scl_in = hold ? 1'b0 : scl;
`endif

  i2c_master_wr #(.CLK_DIV(D)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .addr   (addr),
    .data_in(data_in),
    .sda    (sda),
    .scl    (scl),
    .busy   (busy),
    .done   (done),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in (scl_in),
`endif
    .ack_err(ack_err)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic int m_len();
    return (m_ack_a ? 20 : 11) * B;
  endfunction

  // Expected {scl, sda} for cycle t of the current transaction.
  function automatic logic [1:0] exp_lines(input int t);
    int         b;
    int         ph;
    logic [7:0] ab;
    logic       s;
    logic       sc;
    b  = t / B;
    ph = (t % B) / D;
    ab = {m_addr, 1'b0};
    sc = (ph >= 2) ? 1'b1 : 1'b0;
    if (b == 0) return {1'b1, (ph < 2) ? 1'b1 : 1'b0};
    if (b == (m_ack_a ? 19 : 10)) return {sc, (ph == 3) ? 1'b1 : 1'b0};
    if (b <= 8) s = ab[8 - b];
    else if (b == 9) s = !m_ack_a;
    else if (b <= 17) s = m_data[17 - b];
    else s = !m_ack_d;
    return {sc, s};
  endfunction

  // Model timeline: advances one cycle per clk unless the bus is being stretched.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active  <= 1'b0;
      m_t       <= 0;
      m_ack_err <= 1'b0;
    end else if (m_active) begin
      if (m_t == 9 * B + 3 * D && !m_ack_a) m_ack_err <= 1'b1;
      if (m_t == 18 * B + 3 * D && m_ack_a && !m_ack_d) m_ack_err <= 1'b1;
      if (m_t == m_len() - 1) m_active <= 1'b0;
      else if (!hold) m_t <= m_t + 1;
    end else if (start) begin
      m_active  <= 1'b1;
      m_t       <= 0;
      m_addr    <= addr;
      m_data    <= data_in;
      m_ack_a   <= sl_ack_a;
      m_ack_d   <= sl_ack_d;
      m_ack_err <= 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  int done_seen = 0;
  initial begin
    logic [1:0] e;
    bit         eb;
    bit         ed;
    forever begin
      @(negedge clk);
      if (m_active) begin
        e  = exp_lines(m_t);
        eb = 1'b1;
        ed = (m_t == m_len() - 1);
      end else begin
        e  = 2'b11;
        eb = 1'b0;
        ed = 1'b0;
      end
      chk("scl", int'(scl), int'(e[1]));
      chk("sda", int'(sda), int'(e[0]));
      chk("busy", int'(busy), int'(eb));
      chk("done", int'(done), int'(ed));
      chk("ack_err", int'(ack_err), int'(m_ack_err));
      if (done) done_seen++;
    end
  end

  // Bus decoder: bytes are the first 8 bits sampled on SCL rising after START.
  logic [7:0] byte_q[$];
  int         stops = 0;
  initial begin
    logic       p_scl;
    logic       p_sda;
    logic [7:0] sh;
    int         bcnt;
    p_scl = 1'b1;
    p_sda = 1'b1;
    sh    = '0;
    bcnt  = 0;
    forever begin
      @(negedge clk);
      if (p_scl && scl && p_sda && !sda) begin
        bcnt = 0;
      end else if (p_scl && scl && !p_sda && sda) begin
        stops++;
        bcnt = 0;
      end else if (!p_scl && scl) begin
        sh = {sh[6:0], sda};
        bcnt++;
        if (bcnt == 8) byte_q.push_back(sh);
        if (bcnt == 9) bcnt = 0;
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad,
                         input int exp_lat);
    int n;
    @(negedge clk);
    addr     = a;
    data_in  = d;
    sl_ack_a = aa;
    sl_ack_d = ad;
    byte_q.delete();
    stops    = 0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    chk("ack_err_cleared", int'(ack_err), 0);
    n = 0;
    @(negedge clk);
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n + 1, exp_lat);
    chk("ack_err_end", int'(ack_err), (aa && ad) ? 0 : 1);
    chk("stop_count", stops, 1);
    chk("byte_count", byte_q.size(), aa ? 2 : 1);
    if (byte_q.size() > 0) chk("addr_byte", int'(byte_q[0]), int'({a, 1'b0}));
    if (aa && byte_q.size() > 1) chk("data_byte", int'(byte_q[1]), int'(d));
  endtask

  initial begin
    int d0;
    reset_n = 1'b0;
    start   = 1'b0;
    addr    = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_scl", int'(scl), 1);
    chk("reset_sda", int'(sda), 1);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: compare process checks every cycle.
    repeat (100) @(negedge clk);
    chk("idle_no_done", done_seen, 0);

    run_txn(7'h50, 8'hA5, 1'b1, 1'b1, 320);
    run_txn(7'h50, 8'hA5, 1'b0, 1'b1, 176);
    run_txn(7'h21, 8'h3C, 1'b1, 1'b0, 320);
    run_txn(7'h21, 8'h3C, 1'b1, 1'b1, 320);

    for (int i = 0; i < 8; i++) begin
      logic [6:0] ra;
      logic [7:0] rd;
      bit         raa;
      bit         rad;
      ra  = 7'($urandom);
      rd  = 8'($urandom);
      raa = ($urandom_range(0, 3) != 0);
      rad = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_txn(ra, rd, raa, rad, (raa ? 80 : 44) * D);
    end

    // Start while busy is ignored; async reset mid-transfer releases the lines at once.
    @(negedge clk);
    addr     = 7'h33;
    data_in  = 8'h96;
    sl_ack_a = 1'b1;
    sl_ack_d = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0    = done_seen;
    repeat (49) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_mid", int'(busy), 1);
    repeat (149) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (10) @(negedge clk);
    chk("rst_no_done", done_seen - d0, 0);
    chk("rst_busy_held", int'(busy), 0);
    #2;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    run_txn(7'h0F, 8'hF0, 1'b1, 1'b1, 320);

`ifdef I2C_CLK_STRETCH_EN
    fork
      run_txn(7'h50, 8'hA5, 1'b1, 1'b1, 360);
      begin
        int w;
        w = 0;
        while (!(m_active && m_t == 5 * B + 2 * D) && w < 2000) begin
          @(negedge clk);
          w++;
        end
        hold = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        hold = 1'b0;
      end
    join
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
